cpu4_mc_controller: RTL and testbench
=====================================

CPU4_MC_CONTROLLER -- requirements
Module: cpu4_mc_controller

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1; 1 = FETCH/MEMRD/MEMWR wait for mem_ready, 0 = mem_ready ignored (treated as 1).
REQ-002 Parameter BNE_EN, default 1; 1 = opcode 000101 (bne) decoded, 0 = bne treated as unknown opcode.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 op  input  6  instruction opcode, from instruction register.
REQ-006 funct  input  6  R-type function field.
REQ-007 zero  input  1  ALU zero flag, valid in BRANCH state.
REQ-008 mem_ready  input  1  memory access completes this cycle.
REQ-009 pcen  output  1  PC register write enable.
REQ-010 irwrite  output  1  instruction register write enable.
REQ-011 memwrite, regwrite  output  1 each  memory / register-file write enables.
REQ-012 iord, alusrca, regdst, memtoreg  output  1 each  datapath mux selects.
REQ-013 alusrcb  output  2  00 regB, 01 const 4, 10 signimm, 11 signimm<<2.
REQ-014 pcsrc  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-015 alucontrol  output  3  ALU operation.
REQ-016 state  output  4  current state encoding, debug only.

Function
REQ-017 State encoding SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH on next edge.
REQ-018 Transitions: FETCH->DECODE (on mem_ready); DECODE->MEMADR (lw 100011, sw 101011), RTEX (000000), BRANCH (beq 000100, bne 000101), ADDIEX (001000), JUMP (000010), FETCH (any other op).
REQ-019 Transitions: MEMADR->MEMRD (lw) / MEMWR (sw); MEMRD->MEMWB (on mem_ready); MEMWR->FETCH (on mem_ready); RTEX->RTWB; ADDIEX->ADDIWB; MEMWB, RTWB, ADDIWB, BRANCH, JUMP->FETCH.
REQ-020 In FETCH, MEMRD, MEMWR with MEM_HANDSHAKE=1 and mem_ready=0, state SHALL hold; wait length unbounded.
REQ-021 Mux/ALU selects SHALL be Moore (state only); every signal not listed for a state SHALL be 0.
REQ-022 FETCH: iord=0, alusrca=0, alusrcb=01, pcsrc=00, aluop add; irwrite=pcen=mem_ready.
REQ-023 DECODE: alusrcb=11, aluop add. MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop add.
REQ-024 MEMRD: iord=1. MEMWR: iord=1, memwrite=1 (held for every wait cycle).
REQ-025 MEMWB: memtoreg=1, regwrite=1. RTWB: regdst=1, regwrite=1. ADDIWB: regwrite=1.
REQ-026 RTEX: alusrca=1, alusrcb=00, aluop funct. BRANCH: alusrca=1, alusrcb=00, aluop sub, pcsrc=01.
REQ-027 BRANCH: pcen = zero for beq, ~zero for bne; JUMP: pcsrc=10, pcen=1.
REQ-028 alucontrol: aluop add->010, sub->110; aluop funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other funct->010.
REQ-029 op SHALL be sampled in DECODE and MEMADR only; op changes in other states SHALL NOT affect sequencing.
REQ-030 An instruction SHALL take: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, unknown 2 cycles, plus mem wait cycles.

Reset
REQ-031 On a rising edge with reset=1, state SHALL become FETCH, regardless of current state or pending mem_ready.
REQ-032 While reset=1, pcen, irwrite, memwrite, regwrite SHALL be forced to 0 combinationally.
REQ-033 First cycle after reset deasserts SHALL present FETCH outputs; no other register in the block.

Verification
REQ-034 reset 1 cycle, then lw op, mem_ready=1 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-035 MEM_HANDSHAKE=1, sw, mem_ready=0 for 3 cycles in MEMWR -> state 5 held 4 cycles, memwrite=1 each, then FETCH.
REQ-036 beq zero=1 -> pcen=1 in BRANCH; bne zero=1 -> pcen=0; BNE_EN=0 bne -> DECODE->FETCH, no pcen.
REQ-037 R-type funct 101010 -> alucontrol=111 in RTEX; funct 111111 -> 010; regdst=1 in RTWB.
REQ-038 reset asserted mid-MEMRD with mem_ready=1 -> writes 0 that cycle, state 0 next cycle, no MEMWB.
REQ-039 Unknown op 111111 -> DECODE->FETCH, no write enables asserted.

Source files
------------

// File: rtl/cpu4_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu4_mc_controller
// Description : Multicycle CPU control FSM with Moore datapath selects and
//               memory-handshake wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu4_mc_controller #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int BNE_EN        = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       alusrca,
    output logic       regdst,
    output logic       memtoreg,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;

    localparam logic [1:0] c_aluop_none  = 2'b00;
    localparam logic [1:0] c_aluop_add   = 2'b01;
    localparam logic [1:0] c_aluop_sub   = 2'b10;
    localparam logic [1:0] c_aluop_funct = 2'b11;

    state_t     r_state;
    logic       w_ready;
    logic       w_bne_en;
    logic       w_is_bne;
    logic [1:0] w_aluop;

    assign w_ready  = (MEM_HANDSHAKE == 0) || mem_ready;
    assign w_bne_en = (BNE_EN != 0);
    assign w_is_bne = w_bne_en && (op == c_op_bne);
    assign state    = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  if (w_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        c_op_lw, c_op_sw: r_state <= S_MEMADR;
                        c_op_rtype:       r_state <= S_RTEX;
                        c_op_beq:         r_state <= S_BRANCH;
                        c_op_bne:         r_state <= w_bne_en ? S_BRANCH : S_FETCH;
                        c_op_addi:        r_state <= S_ADDIEX;
                        c_op_j:           r_state <= S_JUMP;
                        default:          r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    if (op == c_op_lw)      r_state <= S_MEMRD;
                    else if (op == c_op_sw) r_state <= S_MEMWR;
                    else                    r_state <= S_FETCH;
                end
                S_MEMRD:  if (w_ready) r_state <= S_MEMWB;
                S_MEMWR:  if (w_ready) r_state <= S_FETCH;
                S_RTEX:   r_state <= S_RTWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Moore decode of the state register; only pcen/irwrite see live inputs.
    always_comb begin
        pcen     = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        iord     = 1'b0;
        alusrca  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        w_aluop  = c_aluop_none;
        case (r_state)
            S_FETCH: begin
                alusrcb = 2'b01;
                w_aluop = c_aluop_add;
                irwrite = w_ready;
                pcen    = w_ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                w_aluop = c_aluop_add;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_aluop = c_aluop_add;
            end
            S_MEMRD:  iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTEX: begin
                alusrca = 1'b1;
                w_aluop = c_aluop_funct;
            end
            S_RTWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                w_aluop = c_aluop_sub;
                pcsrc   = 2'b01;
                pcen    = w_is_bne ? ~zero : zero;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            pcen     = 1'b0;
            irwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
        end
    end

    always_comb begin
        alucontrol = 3'b000;
        case (w_aluop)
            c_aluop_add: alucontrol = 3'b010;
            c_aluop_sub: alucontrol = 3'b110;
            c_aluop_funct: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu4_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu4_mc_controller
// Description : Directed bench for cpu4_mc_controller, two parameter variants
//               checked every cycle against an instruction-path model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu4_mc_controller;

    localparam logic [5:0] c_lw   = 6'b100011;
    localparam logic [5:0] c_sw   = 6'b101011;
    localparam logic [5:0] c_rt   = 6'b000000;
    localparam logic [5:0] c_beq  = 6'b000100;
    localparam logic [5:0] c_bne  = 6'b000101;
    localparam logic [5:0] c_addi = 6'b001000;
    localparam logic [5:0] c_j    = 6'b000010;
    localparam logic [5:0] c_unk  = 6'b111111;

    localparam int K_NONE = 0, K_MEM = 1, K_LW = 2, K_SW = 3,
                   K_R = 4, K_ADDI = 5, K_BR = 6, K_J = 7;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] op, funct;
    logic       pcen [2], irwrite [2], memwrite [2], regwrite [2];
    logic       iord [2], alusrca [2], regdst [2], memtoreg [2];
    logic [1:0] alusrcb [2], pcsrc [2];
    logic [2:0] alucontrol [2];
    logic [3:0] state [2];

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;
    int m_kind [2] = '{0, 0};
    int m_step [2] = '{0, 0};

    always #5 clk = ~clk;

    cpu4_mc_controller #(.MEM_HANDSHAKE(1), .BNE_EN(1)) u_dut0 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen[0]), .irwrite(irwrite[0]),
        .memwrite(memwrite[0]), .regwrite(regwrite[0]), .iord(iord[0]),
        .alusrca(alusrca[0]), .regdst(regdst[0]), .memtoreg(memtoreg[0]),
        .alusrcb(alusrcb[0]), .pcsrc(pcsrc[0]), .alucontrol(alucontrol[0]),
        .state(state[0])
    );

    cpu4_mc_controller #(.MEM_HANDSHAKE(0), .BNE_EN(0)) u_dut1 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen[1]), .irwrite(irwrite[1]),
        .memwrite(memwrite[1]), .regwrite(regwrite[1]), .iord(iord[1]),
        .alusrca(alusrca[1]), .regdst(regdst[1]), .memtoreg(memtoreg[1]),
        .alusrcb(alusrcb[1]), .pcsrc(pcsrc[1]), .alucontrol(alucontrol[1]),
        .state(state[1])
    );

    // Instance 0 has handshake and bne enabled; instance 1 has both disabled.
    function automatic int classify(input logic [5:0] o, input int d);
        case (o)
            c_lw, c_sw: return K_MEM;
            c_rt:       return K_R;
            c_beq:      return K_BR;
            c_bne:      return (d == 0) ? K_BR : K_NONE;
            c_addi:     return K_ADDI;
            c_j:        return K_J;
            default:    return K_NONE;
        endcase
    endfunction

    function automatic int path_len(input int k);
        case (k)
            K_LW:             return 5;
            K_SW, K_R, K_ADDI: return 4;
            K_BR, K_J:        return 3;
            default:          return 2;
        endcase
    endfunction

    function automatic int path_state(input int k, input int s);
        if (s == 0) return 0;
        if (s == 1) return 1;
        case (k)
            K_MEM:   return 2;
            K_LW:    return (s == 2) ? 2 : (s == 3) ? 3 : 4;
            K_SW:    return (s == 2) ? 2 : 5;
            K_R:     return (s == 2) ? 6 : 7;
            K_ADDI:  return (s == 2) ? 9 : 10;
            K_BR:    return 8;
            K_J:     return 11;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // {state, pcen, irwrite, memwrite, regwrite, iord, alusrca, regdst,
    //  memtoreg, alusrcb, pcsrc, alucontrol}
    function automatic logic [18:0] model_out(input int st, input int d);
        logic [3:0] s4;
        logic pe, ir, mw, rw, io, sa, rd, mr;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        logic rdy;
        s4 = 4'(st);
        {pe, ir, mw, rw, io, sa, rd, mr} = 8'h00;
        sb = 2'b00; ps = 2'b00; ac = 3'b000;
        rdy = (d == 1) || mem_ready;
        case (st)
            0:    begin sb = 2'b01; ac = 3'b010; ir = rdy; pe = rdy; end
            1:    begin sb = 2'b11; ac = 3'b010; end
            2, 9: begin sa = 1'b1; sb = 2'b10; ac = 3'b010; end
            3:    io = 1'b1;
            4:    begin mr = 1'b1; rw = 1'b1; end
            5:    begin io = 1'b1; mw = 1'b1; end
            6:    begin sa = 1'b1; ac = funct_alu(funct); end
            7:    begin rd = 1'b1; rw = 1'b1; end
            8:    begin sa = 1'b1; ac = 3'b110; ps = 2'b01;
                        pe = (op == c_bne) ? ~zero : zero; end
            10:   rw = 1'b1;
            11:   begin ps = 2'b10; pe = 1'b1; end
            default: ;
        endcase
        if (reset) {pe, ir, mw, rw} = 4'b0000;
        return {s4, pe, ir, mw, rw, io, sa, rd, mr, sb, ps, ac};
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int st, k, s;
            k  = m_kind[d];
            s  = m_step[d];
            st = path_state(k, s);
            if (reset) begin
                k = K_NONE; s = 0;
            end else if (d == 0 && !mem_ready && (st == 0 || st == 3 || st == 5)) begin
                k = k;
            end else if (s == 0) begin
                s = 1;
            end else if (s == 1) begin
                k = classify(op, d);
                s = (k == K_NONE) ? 0 : 2;
            end else if (s == 2 && k == K_MEM) begin
                k = (op == c_lw) ? K_LW : (op == c_sw) ? K_SW : K_NONE;
                s = (k == K_NONE) ? 0 : 3;
            end else if (s + 1 >= path_len(k)) begin
                k = K_NONE; s = 0;
            end else begin
                s = s + 1;
            end
            m_kind[d] <= k;
            m_step[d] <= s;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                logic [18:0] act, exp;
                exp = model_out(path_state(m_kind[d], m_step[d]), d);
                act = {state[d], pcen[d], irwrite[d], memwrite[d], regwrite[d],
                       iord[d], alusrca[d], regdst[d], memtoreg[d], alusrcb[d],
                       pcsrc[d], alucontrol[d]};
                checks++;
                if (act !== exp) begin
                    failures++;
                    $display("FAIL model_cmp dut%0d t=%0t actual=%05h expected=%05h",
                             d, $time, act, exp);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        chk("reset_state0", int'(state[0]), 0);
        chk("reset_irwrite_forced", int'(irwrite[0]), 0);
        reset = 1'b0;
    endtask

    int lw_seq [6] = '{0, 1, 2, 3, 4, 0};
    int bne_seq1 [3] = '{0, 1, 0};
    logic [5:0] fl [6] = '{6'b100000, 6'b100010, 6'b100100,
                           6'b100101, 6'b101010, 6'b111111};

    initial begin
        reset = 1'b1; op = c_lw; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
        tick();
        started = 1'b1;

        // lw with ready memory: 0,1,2,3,4,0 and writeback only in state 4
        do_reset();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("lw_trace%0d", i), int'(state[0]), lw_seq[i]);
            chk($sformatf("lw_regwrite%0d", i), int'(regwrite[0]), (lw_seq[i] == 4) ? 1 : 0);
            tick();
        end

        // sw with three not-ready cycles in MEMWR
        do_reset();
        op = c_sw;
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i < 3) ? 1'b0 : 1'b1;
            #1;
            chk($sformatf("sw_wait_state%0d", i), int'(state[0]), 5);
            chk($sformatf("sw_wait_memwrite%0d", i), int'(memwrite[0]), 1);
            tick();
        end
        chk("sw_done_fetch", int'(state[0]), 0);

        // FETCH stall with jump; instance 1 ignores mem_ready
        do_reset();
        op = c_j; mem_ready = 1'b0;
        tick(); tick();
        chk("fetch_hold", int'(state[0]), 0);
        chk("fetch_hold_pcen", int'(pcen[0]), 0);
        chk("nohs_jump_state", int'(state[1]), 11);
        chk("nohs_jump_pcsrc", int'(pcsrc[1]), 2);
        mem_ready = 1'b1;
        tick(); tick();
        chk("jump_state", int'(state[0]), 11);
        tick();

        // beq taken, bne with zero=1 (not taken), bne disabled on instance 1
        do_reset();
        op = c_beq; zero = 1'b1;
        tick(); tick();
        chk("beq_state", int'(state[0]), 8);
        chk("beq_pcen", int'(pcen[0]), 1);
        tick();
        do_reset();
        op = c_bne;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bne_off_trace%0d", i), int'(state[1]), bne_seq1[i]);
            if (i == 2) chk("bne_pcen_zero1", int'(pcen[0]), 0);
            tick();
        end
        zero = 1'b0;
        do_reset();
        tick(); tick();
        tick();

        // R-type over the funct table
        for (int i = 0; i < 6; i++) begin
            do_reset();
            op = c_rt; funct = fl[i];
            tick(); tick();
            if (i == 4) chk("rt_slt_alu", int'(alucontrol[0]), 7);
            if (i == 5) chk("rt_other_alu", int'(alucontrol[0]), 2);
            tick();
            chk("rtwb_regdst", int'(regdst[0]), 1);
            tick();
        end

        // addi path
        do_reset();
        op = c_addi;
        repeat (5) tick();

        // op changes during MEMRD stall must not alter sequencing
        do_reset();
        op = c_lw;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        tick(); tick();
        chk("memrd_hold", int'(state[0]), 3);
        op = c_rt; mem_ready = 1'b1;
        tick();
        chk("memrd_to_memwb", int'(state[0]), 4);
        tick();

        // reset in MEMRD with mem_ready=1
        do_reset();
        op = c_lw;
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        chk("rst_memrd_we", int'({pcen[0], irwrite[0], memwrite[0], regwrite[0]}), 0);
        tick();
        chk("rst_memrd_state", int'(state[0]), 0);
        reset = 1'b0;
        tick();
        chk("rst_memrd_resume", int'(state[0]), 1);

        // unknown opcode
        do_reset();
        op = c_unk;
        tick();
        chk("unk_decode", int'(state[0]), 1);
        chk("unk_writes", int'({memwrite[0], regwrite[0]}), 0);
        tick();
        chk("unk_fetch", int'(state[0]), 0);
        tick();

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
